oam_dma_ctrl: RTL and testbench

- Sprite (OAM) DMA engine and bus master mux, downstream of the CPU core's bus outputs and upstream of the system bus.
- Snoops CPU writes to the DMA trigger register. Stalls the core through its ready input.
- Copies 256 bytes from page $XX00–$XXFF to the OAM data port, one read cycle plus one write cycle per byte.
- Keeps its own CPU-cycle timebase, phase-aligned with the core from reset release.

---
 rtl/oam_dma_ctrl.sv | 122 ++++++++++++
 tb/tb_oam_dma_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
`timescale 1ns/1ps
// Sprite DMA engine and bus master mux: snoops CPU trigger writes, stalls the core, and copies a 256-byte page to the OAM port.
// Optional macro OAMDMA_ALIGN_EN inserts a get/put alignment cycle when the halt cycle lands on an odd CPU cycle.
module oam_dma_ctrl #(
  parameter int          CYCLE_CLKS = 12,
  parameter logic [15:0] DMA_REG    = 16'h4014,
  parameter logic [15:0] OAM_PORT   = 16'h2004
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_addr,
  input  logic [7:0]  I_wr_data,
  input  logic        I_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_ready,
  output logic        O_busy
);

  localparam int DW = (CYCLE_CLKS > 1) ? $clog2(CYCLE_CLKS) : 1;

`ifdef OAMDMA_ALIGN_EN
  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE, ALIGN} state_t;
  logic parity;
`else
  typedef enum logic [1:0] {IDLE, HALT, READ, WRITE} state_t;
`endif

  state_t        state;
  logic [DW-1:0] div;
  logic [7:0]    idx;
  logic [7:0]    page;
  logic [7:0]    data;
  logic          cyc_end;

  assign cyc_end = (div == DW'(CYCLE_CLKS - 1));

  always_ff @(posedge I_clock or posedge I_reset) begin
    if (I_reset) begin
      div     <= '0;
      state   <= IDLE;
      idx     <= 8'd0;
      page    <= 8'd0;
      data    <= 8'd0;
      O_ready <= 1'b1;
      O_busy  <= 1'b0;
`ifdef OAMDMA_ALIGN_EN
      parity  <= 1'b0;
`endif
    end else begin
      if (cyc_end) begin
        div <= '0;
`ifdef OAMDMA_ALIGN_EN
        parity <= ~parity;
`endif
      end else begin
        div <= div + DW'(1);
      end

      if (cyc_end) begin
        case (state)
          IDLE: begin
            if (!I_rdwr && (I_addr == DMA_REG)) begin
              page    <= I_wr_data;
              state   <= HALT;
              O_ready <= 1'b0;
              O_busy  <= 1'b1;
            end
          end
          HALT: begin
`ifdef OAMDMA_ALIGN_EN
            state <= parity ? ALIGN : READ;
`else
            state <= READ;
`endif
          end
`ifdef OAMDMA_ALIGN_EN
          ALIGN: state <= READ;
`endif
          READ: begin
            data  <= I_rd_data;
            state <= WRITE;
          end
          WRITE: begin
            idx <= idx + 8'd1;
            if (idx == 8'hFF) begin
              state   <= IDLE;
              O_ready <= 1'b1;
              O_busy  <= 1'b0;
            end else begin
              state <= READ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Halt/align cycles pass the stalled core's held outputs straight through.
  always_comb begin
    O_addr    = I_addr;
    O_wr_data = I_wr_data;
    O_rdwr    = I_rdwr;
    case (state)
      READ: begin
        O_addr    = {page, idx};
        O_wr_data = data;
        O_rdwr    = 1'b1;
      end
      WRITE: begin
        O_addr    = OAM_PORT;
        O_wr_data = data;
        O_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
`timescale 1ns/1ps
// Bench for oam_dma_ctrl: vector table for idle snooping, randomized pass-through, and DMA transfers checked against a cycle-sequence model.
module tb_oam_dma_ctrl;

  localparam int          CYC      = 12;
  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;
`ifdef OAMDMA_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        I_clock = 1'b0;
  logic        I_reset = 1'b1;
  logic [15:0] I_addr = 16'h0000;
  logic [7:0]  I_wr_data = 8'h00;
  logic        I_rdwr = 1'b1;
  logic [7:0]  I_rd_data;
  logic [15:0] O_addr;
  logic [7:0]  O_wr_data;
  logic        O_rdwr;
  logic        O_ready;
  logic        O_busy;

  oam_dma_ctrl dut (
    .I_clock(I_clock), .I_reset(I_reset), .I_addr(I_addr), .I_wr_data(I_wr_data),
    .I_rdwr(I_rdwr), .I_rd_data(I_rd_data), .O_addr(O_addr), .O_wr_data(O_wr_data),
    .O_rdwr(O_rdwr), .O_ready(O_ready), .O_busy(O_busy)
  );

  always #5 I_clock = ~I_clock;

  // Memory: every byte holds its low address byte xor 5A.
  assign I_rd_data = O_addr[7:0] ^ 8'h5A;

  // Master clock edges since reset release; CPU cycle = n_edges/12.
  int n_edges;
  always @(posedge I_clock or posedge I_reset)
    if (I_reset) n_edges <= 0;
    else         n_edges <= n_edges + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc_end();
    forever begin
      @(posedge I_clock);
      #1;
      if (n_edges % CYC == 0) break;
    end
  endtask

  // Trigger a DMA of page pg and check the whole bus sequence against the model.
  // want = parity of the halt cycle to line up with, or -1 to trigger right away.
  task automatic dma(input logic [7:0] pg, input int want, input string nm);
    int halt_par, stall, exp_cyc, errs, al, guard, busy_err;
    logic [15:0] exp_addr[$];
    logic        exp_rdwr[$];
    logic [7:0]  exp_data[$];
    logic [15:0] obs_addr[$];
    logic        obs_rdwr[$];
    logic [7:0]  obs_data[$];

    @(negedge I_clock);
    if (want >= 0)
      while ((((n_edges / CYC) + 1) % 2) != want) @(negedge I_clock);
    I_addr = DMA_REG; I_wr_data = pg; I_rdwr = 1'b0;
    wait_cyc_end();
    halt_par = (n_edges / CYC) % 2;
    chk({nm, "_ready_fall"}, O_ready, 1'b0);
    chk({nm, "_busy_rise"}, O_busy, 1'b1);
    if (want >= 0) chk({nm, "_halt_parity"}, halt_par, want);
    @(negedge I_clock);
    I_addr = 16'h8000; I_wr_data = 8'hEE; I_rdwr = 1'b1;

    al = (ALIGN && halt_par == 1) ? 1 : 0;
    exp_cyc = 513 + al;
    for (int k = 0; k < 1 + al; k++) begin
      exp_addr.push_back(16'h8000); exp_rdwr.push_back(1'b1); exp_data.push_back(8'hEE);
    end
    for (int i = 0; i < 256; i++) begin
      exp_addr.push_back({pg, 8'(i)}); exp_rdwr.push_back(1'b1); exp_data.push_back(8'h00);
      exp_addr.push_back(OAM_PORT); exp_rdwr.push_back(1'b0); exp_data.push_back(8'(i) ^ 8'h5A);
    end

    stall = 0; guard = 0; busy_err = 0;
    while (O_ready == 1'b0 && guard < 600 * CYC) begin
      stall++; guard++;
      if (O_busy !== 1'b1) busy_err++;
      if (n_edges % CYC == CYC - 1) begin
        obs_addr.push_back(O_addr); obs_rdwr.push_back(O_rdwr); obs_data.push_back(O_wr_data);
      end
      @(negedge I_clock);
    end

    chk({nm, "_stall_clks"}, stall, exp_cyc * CYC);
    chk({nm, "_cycles"}, obs_addr.size(), exp_cyc);
    chk({nm, "_busy_during"}, busy_err, 0);
    errs = 0;
    for (int k = 0; k < exp_addr.size() && k < obs_addr.size(); k++) begin
      if (obs_addr[k] !== exp_addr[k] || obs_rdwr[k] !== exp_rdwr[k]) errs++;
      else if (exp_rdwr[k] == 1'b0 && obs_data[k] !== exp_data[k]) errs++;
    end
    chk({nm, "_seq_errs"}, errs, 0);
    if (obs_addr.size() > 1 + al)
      chk({nm, "_first_rd"}, obs_addr[1 + al], {pg, 8'h00});
    if (obs_addr.size() >= 2)
      chk({nm, "_last_rd"}, obs_addr[obs_addr.size() - 2], {pg, 8'hFF});
    chk({nm, "_ready_back"}, O_ready, 1'b1);
    chk({nm, "_busy_back"}, O_busy, 1'b0);
    chk({nm, "_passthru_after"}, O_addr, 16'h8000);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        rdwr;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int rd;
    int guard;
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;

    tbl[0] = '{16'h4015, 8'h02, 1'b0, 1'b1};
    tbl[1] = '{16'h4014, 8'h02, 1'b1, 1'b1};
    tbl[2] = '{16'h2004, 8'h33, 1'b0, 1'b1};
    tbl[3] = '{16'h4013, 8'h02, 1'b0, 1'b1};
    tbl[4] = '{16'h0014, 8'h40, 1'b0, 1'b1};

    // Reset state with pass-through
    I_addr = 16'h1234; I_wr_data = 8'hA5; I_rdwr = 1'b0;
    repeat (3) @(negedge I_clock);
    #1;
    chk("rst_ready", O_ready, 1'b1);
    chk("rst_busy", O_busy, 1'b0);
    chk("rst_addr", O_addr, 16'h1234);
    chk("rst_wdata", O_wr_data, 8'hA5);
    chk("rst_rdwr", O_rdwr, 1'b0);
    @(negedge I_clock);
    I_reset = 1'b0;
    I_addr = 16'h8000; I_rdwr = 1'b1;

    // Non-trigger accesses held across a CPU cycle end
    for (int v = 0; v < 5; v++) begin
      @(negedge I_clock);
      I_addr = tbl[v].addr; I_wr_data = tbl[v].wd; I_rdwr = tbl[v].rdwr;
      #1;
      chk($sformatf("vec%0d_addr", v), O_addr, tbl[v].addr);
      chk($sformatf("vec%0d_wd", v), O_wr_data, tbl[v].wd);
      chk($sformatf("vec%0d_rdwr", v), O_rdwr, tbl[v].rdwr);
      wait_cyc_end();
      chk($sformatf("vec%0d_ready", v), O_ready, tbl[v].exp_ready);
      chk($sformatf("vec%0d_busy", v), O_busy, !tbl[v].exp_ready);
    end

    // Random idle pass-through
    for (int i = 0; i < 40; i++) begin
      @(negedge I_clock);
      a = 16'($urandom); d = 8'($urandom); r = 1'($urandom_range(0, 1));
      if (a == DMA_REG) a = 16'h4015;
      I_addr = a; I_wr_data = d; I_rdwr = r;
      #1;
      chk("rnd_addr", O_addr, a);
      chk("rnd_wd", O_wr_data, d);
      chk("rnd_rdwr", O_rdwr, r);
      chk("rnd_ready", O_ready, 1'b1);
    end
    @(negedge I_clock);
    I_addr = 16'h8000; I_rdwr = 1'b1;

    dma(8'h02, 0, "p02_even");
    dma(8'h02, 1, "p02_odd");
    dma(8'hFF, -1, "pFF");
    dma(8'h03, -1, "p03");
    dma(8'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "prnd");

    // Abort mid-transfer at byte 100
    @(negedge I_clock);
    I_addr = DMA_REG; I_wr_data = 8'h05; I_rdwr = 1'b0;
    wait_cyc_end();
    @(negedge I_clock);
    I_addr = 16'h8000; I_rdwr = 1'b1;
    rd = 0; guard = 0;
    while (rd < 101 && guard < 400 * CYC) begin
      guard++;
      if (n_edges % CYC == CYC - 1 && O_rdwr && O_addr[15:8] == 8'h05 && !O_ready) rd++;
      if (rd < 101) @(negedge I_clock);
    end
    chk("abort_at_byte100", O_addr, 16'h0564);
    I_reset = 1'b1;
    #1;
    chk("abort_ready", O_ready, 1'b1);
    chk("abort_busy", O_busy, 1'b0);
    chk("abort_passthru", O_addr, 16'h8000);
    @(negedge I_clock);
    I_reset = 1'b0;
    dma(8'h07, -1, "p07_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
